// File: rtl/if_refill.sv
// I-cache line refill engine: turns an IF-stage miss into a B-beat read burst,
// writes each beat into the data array, then commits tag+valid into the LRU way.
module if_refill #(
  parameter int N = 2,
  parameter int B = 8,
  parameter int S = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   IF_miss,
  input  logic [63:0]                            IF_addr,
  input  logic [((N>1)?$clog2(N):1)-1:0]         lru_way,
  input  logic                                   flush,
  output logic [63:0]                            m_araddr,
  output logic                                   m_arvalid,
  input  logic                                   m_arready,
  input  logic [63:0]                            m_rdata,
  input  logic                                   m_rvalid,
  input  logic                                   m_rlast,
  output logic                                   m_rready,
  output logic                                   fill_we,
  output logic [$clog2(S)-1:0]                   fill_set,
  output logic [((N>1)?$clog2(N):1)-1:0]         fill_way,
  output logic [$clog2(B)-1:0]                   fill_word,
  output logic [63:0]                            fill_data,
  output logic                                   fill_tag_we,
  output logic [63-$clog2(S)-$clog2(B)-3:0]      fill_tag,
  output logic                                   refill_busy,
  output logic                                   refill_err
);
  localparam int WW = (N > 1) ? $clog2(N) : 1;
  localparam int SB = $clog2(S);
  localparam int BB = $clog2(B);
  localparam int YB = 3;
  localparam int TB = 64 - SB - BB - YB;
  localparam int LB = TB + SB;

  typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, COMMIT} state_t;

  state_t          state, nxt;
  logic [LB-1:0]   line_q;
  logic [WW-1:0]   way_q;
  logic [BB-1:0]   cnt;
  logic            beat, last_beat, accept;

  assign last_beat   = (cnt == BB'(B-1));
  assign accept      = (state == IDLE) && IF_miss && !flush;
  assign refill_busy = (state != IDLE);
  assign m_araddr    = {line_q, {(BB+YB){1'b0}}};
  assign fill_set    = line_q[SB-1:0];
  assign fill_tag    = line_q[LB-1:SB];
  assign fill_way    = way_q;
  assign fill_word   = cnt;
  assign fill_data   = fill_we ? m_rdata : 64'd0;

  logic unused_addr_lo;
  assign unused_addr_lo = ^IF_addr[BB+YB-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt         = state;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    fill_we     = 1'b0;
    fill_tag_we = 1'b0;
    beat        = 1'b0;
    case (state)
      IDLE:   if (IF_miss && !flush) nxt = REQ;
      REQ: begin
        m_arvalid = 1'b1;
        // a request already accepted cannot be withdrawn; its beats must be drained
        if (m_arready)  nxt = flush ? DRAIN : DATA;
        else if (flush) nxt = IDLE;
      end
      DATA: begin
        m_rready = 1'b1;
        beat     = m_rvalid;
        fill_we  = m_rvalid && !flush;
        if (beat && last_beat) nxt = flush ? IDLE : COMMIT;
        else if (flush)        nxt = DRAIN;
      end
      DRAIN: begin
        m_rready = 1'b1;
        beat     = m_rvalid;
        if (beat && last_beat) nxt = IDLE;
      end
      COMMIT: begin
        fill_tag_we = 1'b1;
        nxt         = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q     <= '0;
      way_q      <= '0;
      cnt        <= '0;
      refill_err <= 1'b0;
    end else begin
      if (accept) begin
        line_q <= IF_addr[63:BB+YB];
        way_q  <= lru_way;
        cnt    <= '0;
      end else if (beat) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
        // completion is decided by the count; rlast only flags a protocol error
        if (m_rlast != last_beat) refill_err <= 1'b1;
      end
    end
  end
endmodule
